// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial-product step per
// clock, go/done start handshake, current FSM state visible on CS.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           CS
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: go is a level sampled only in IDLE; once accepted, a/b are
  // captured and ignored until the next accept. done stays high in DONE until
  // go is seen low, so a go held high never launches a second operation.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_mreg;
  logic [WIDTH-1:0]     r_qreg;
  logic [WIDTH-1:0]     r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_shifted;
  logic                 w_last;

  assign w_last    = (r_cnt == CW'(1));
  assign w_addend  = r_qreg[0] ? {1'b0, r_mreg} : '0;
  assign w_sum     = {1'b0, r_acc} + w_addend;
  // Carry lands in the acc MSB, sum[0] lands in the qreg MSB.
  assign w_shifted = {w_sum, r_qreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = go ? S_RUN : S_IDLE;
      S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next_state = go ? S_DONE : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // An illegal state clears the datapath exactly as reset does.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_BAD)) begin
      r_mreg    <= '0;
      r_qreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_mreg <= a;
            r_qreg <= b;
            r_acc  <= '0;
            r_cnt  <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          r_acc  <= w_shifted[2*WIDTH-1:WIDTH];
          r_qreg <= w_shifted[WIDTH-1:0];
          r_cnt  <= r_cnt - CW'(1);
          if (w_last) begin
            r_product <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign CS      = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=4 and a WIDTH=8 instance, directed vectors,
// expected products queued at issue and popped by monitors on each done rise.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        go4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  product4;
  logic        busy4;
  logic        done4;
  logic [1:0]  cs4;

  logic        go8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] product8;
  logic        busy8;
  logic        done8;
  logic [1:0]  cs8;

  logic [7:0]  exp_q4[$];
  logic [15:0] exp_q8[$];

  int total;
  int bad;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .go(go4), .a(a4), .b(b4),
    .product(product4), .busy(busy4), .done(done4), .CS(cs4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .go(go8), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .done(done8), .CS(cs8)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitors: pop and compare on each rising edge of done
  logic prev_done4 = 1'b0;
  logic prev_done8 = 1'b0;

  always @(negedge clk) begin
    if (done4 && !prev_done4) begin
      if (exp_q4.size() == 0) begin
        check("unexpected_done4", 32'(product4), 32'hDEAD);
      end else begin
        check("product4", 32'(product4), 32'(exp_q4.pop_front()));
      end
    end
    prev_done4 = done4;
  end

  always @(negedge clk) begin
    if (done8 && !prev_done8) begin
      if (exp_q8.size() == 0) begin
        check("unexpected_done8", 32'(product8), 32'hDEAD);
      end else begin
        check("product8", 32'(product8), 32'(exp_q8.pop_front()));
      end
    end
    prev_done8 = done8;
  end

  // driver: one WIDTH=4 operation; optionally change operands after the
  // first RUN edge, optionally keep go high through DONE
  task automatic op4(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp_p,
                     input bit keep_go, input bit chg, input logic [3:0] ca, input logic [3:0] cb);
    check("cs_idle_before", 32'(cs4), 32'd0);
    a4  = va;
    b4  = vb;
    go4 = 1'b1;
    exp_q4.push_back(exp_p);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!keep_go) go4 = 1'b0;
      if (chg && i == 1) begin
        a4 = ca;
        b4 = cb;
      end
      check("cs_run", 32'(cs4), 32'd1);
      check("busy_run", 32'(busy4), 32'd1);
      check("done_run", 32'(done4), 32'd0);
    end
    tick();
    check("cs_done", 32'(cs4), 32'd2);
    check("done_done", 32'(done4), 32'd1);
    check("busy_done", 32'(busy4), 32'd0);
    if (!keep_go) begin
      tick();
      check("cs_back_idle", 32'(cs4), 32'd0);
      check("product_hold_idle", 32'(product4), 32'(exp_p));
    end
  endtask

  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp_p);
    int n;
    a8  = va;
    b8  = vb;
    go8 = 1'b1;
    exp_q8.push_back(exp_p);
    tick();
    go8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      tick();
      n++;
    end
    check("latency8", 32'(n), 32'd8);
    tick();
    check("cs8_back_idle", 32'(cs8), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    go4 = 1'b0; a4 = '0; b4 = '0;
    go8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    rst = 1'b0;
    check("rst_cs", 32'(cs4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_product", 32'(product4), 32'd0);
    check("rst_product8", 32'(product8), 32'd0);

    // basic 13*11
    op4(4'd13, 4'd11, 8'h8F, 1'b0, 1'b0, 4'd0, 4'd0);

    // go held through DONE: no restart
    op4(4'd15, 4'd15, 8'hE1, 1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cs_hold_done", 32'(cs4), 32'd2);
      check("product_hold_done", 32'(product4), 32'hE1);
    end
    go4 = 1'b0;
    tick();
    check("cs_release", 32'(cs4), 32'd0);
    check("product_release", 32'(product4), 32'hE1);

    // zero and one operands
    op4(4'd0, 4'd9, 8'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    op4(4'd9, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    op4(4'd1, 4'd15, 8'd15, 1'b0, 1'b0, 4'd0, 4'd0);

    // operands changed mid-run are ignored
    op4(4'd6, 4'd7, 8'd42, 1'b0, 1'b1, 4'd15, 4'd15);

    // reset during RUN aborts with no result
    a4 = 4'd13; b4 = 4'd11; go4 = 1'b1;
    tick();
    go4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cs", 32'(cs4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_product", 32'(product4), 32'd0);
    tick();
    check("abort_stays_idle", 32'(cs4), 32'd0);
    op4(4'd3, 4'd5, 8'd15, 1'b0, 1'b0, 4'd0, 4'd0);

    // WIDTH=8 corner
    op8(8'd255, 8'd255, 16'hFE01);
    op8(8'd200, 8'd3, 16'd600);

    // exhaustive 4-bit sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), 8'(x * y), 1'b0, 1'b0, 4'd0, 4'd0);
      end
    end

    tick();
    tick();
    check("q4_drained", 32'(exp_q4.size()), 32'd0);
    check("q8_drained", 32'(exp_q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
